hazard_ctrl_seq: RTL and testbench
==================================

# hazard_ctrl_seq

Sequential pipeline hazard controller for the 5-stage CPU. It extends the purely combinational flush/stall logic with three additions: a configurable branch-resolution stage, a multi-cycle mul/div stall FSM, and a data-memory wait handshake. It also holds exceptions arriving during a memory stall until the stall ends, and keeps saturating stall/flush performance counters. It sits beside the pipeline registers and drives their flush and hold controls plus the PC hold.

## Interface
- `BRANCH_STAGE`, 1: 0 = branch resolved in ID (flush IF/ID only); 1 = resolved in EX (flush IF/ID and ID/EX).
- `MULDIV_LAT`, 8: cycles a mul/div occupies EX; legal range 2..255.
- `CNT_W`, 16: perf counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `jump` in 1: jump decoded in ID.
- `true_branch` in 1: taken branch, from the stage chosen by `BRANCH_STAGE`.
- `loaduse_stall` in 1: load-use dependency detected in ID.
- `muldiv_start` in 1: mul/div instruction present in EX.
- `mem_req` in 1: MEM-stage access valid.
- `mem_ready` in 1: data memory completes the access this cycle.
- `exception` in 1: exception raised in MEM, one-cycle pulse.
- `cnt_clr` in 1: synchronous clear of both counters.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: bubble insert.
- `pc_holdon`, `ifid_holdon`, `idex_holdon`, `exmem_holdon` out 1 each: register freeze.
- `muldiv_done` out 1: final EX cycle of a mul/div; result is valid.
- `stall_cnt` out CNT_W: cycles with `pc_holdon`=1, saturating.
- `flush_cnt` out CNT_W: cycles with any flush=1, saturating.

## Operation
- Registered state: FSM {IDLE, MULDIV, MEMWAIT}, 8-bit `md_cnt`, `exc_pending`, two counters.
- `mem_stall` = `mem_req` & !`mem_ready`.
- Outputs are combinational from state and inputs. Per-cycle priority, highest first:
  1. Exception, when `exception` | `exc_pending` and !`mem_stall`: `ifid_flush`, `idex_flush`, `exmem_flush` = 1; no holds. FSM goes to IDLE (an active mul/div is aborted); `exc_pending` is cleared.
  2. `mem_stall`: all four holds = 1; no flushes; FSM goes to MEMWAIT. If `exception` is asserted this cycle, set `exc_pending`.
  3. Mul/div, when state is MULDIV, or state is IDLE with `muldiv_start`: `pc_holdon`, `ifid_holdon`, `idex_holdon` = 1 and `exmem_flush` = 1.
     - From IDLE: load `md_cnt` = MULDIV_LAT-1, go to MULDIV.
     - In MULDIV: decrement `md_cnt`. When `md_cnt`==1, assert `muldiv_done`, and on the next edge go to IDLE.
  4. Redirect in EX, when `BRANCH_STAGE`=1 and `true_branch`: `ifid_flush`, `idex_flush` = 1. This overrides `loaduse_stall` (the stalled ID instruction is on the wrong path).
  5. `loaduse_stall`: `pc_holdon`, `ifid_holdon`, `idex_flush` = 1. This overrides ID-stage redirects (`jump`, and `true_branch` when `BRANCH_STAGE`=0), which stay asserted and are taken after the stall.
  6. `jump`, or `true_branch` when `BRANCH_STAGE`=0: `ifid_flush` = 1.
- MEMWAIT exits when `mem_ready`: to IDLE, or to MULDIV if MULDIV was interrupted. `md_cnt` is frozen while stalled on memory.
- `muldiv_start` arriving during MEMWAIT is ignored. The instruction is held in EX and re-presents `muldiv_start` after release.
- Counters increment by 1 per qualifying cycle and hold at all-ones. `cnt_clr` has priority over increment.

## Timing
- Reset values:
  - State IDLE, `md_cnt` 0, `exc_pending` 0, both counters 0.
  - All flush, hold and `muldiv_done` outputs are 0 for any input combination while `rst_n`=0.
- A redirect or load-use response appears in the same cycle as its input (zero latency).
- Mul/div holds the front of the pipeline for exactly MULDIV_LAT cycles counted from the `muldiv_start` cycle. `muldiv_done` is high in the last of those cycles.
- A pending exception flushes in the first cycle with `mem_ready`=1 or `mem_req`=0 after the stall.
- Reset asserted mid-MULDIV or mid-MEMWAIT returns to IDLE immediately and drops all holds.

## Test plan
- Reset: `rst_n`=0 with all inputs 1 → all outputs 0 and counters 0. After release with only `jump`=1 → `ifid_flush`=1, `flush_cnt`=1 after the edge.
- Mul/div, MULDIV_LAT=8: `muldiv_start` pulse → `pc_holdon`=1 for exactly 8 cycles and `muldiv_done` on the 8th only; `stall_cnt`=8.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles → all holds=1 for 3 cycles. `exception` pulsed in stall cycle 2 → the 3 flushes assert in the release cycle only.
- BRANCH_STAGE=1 with `true_branch`=1 and `loaduse_stall`=1 → `ifid_flush`=`idex_flush`=1 and `pc_holdon`=0. BRANCH_STAGE=0 with the same inputs → `pc_holdon`=1, `idex_flush`=1, `ifid_flush`=0.
- Exception at MULDIV cycle 4 → flushes that cycle; next cycle IDLE, `pc_holdon`=0, and `muldiv_done` is never asserted.
- Saturation: CNT_W=4 with 20 stalled cycles → `stall_cnt`=15. `cnt_clr` → 0 the next cycle.

Source files
------------

// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq
// Sequential hazard controller for the 5-stage pipeline. It drives the flush
// (bubble) and hold (freeze) controls of the pipeline registers and the PC hold.
// The pipeline events it handles are:
//   - ID or EX branch redirects.
//   - Load-use stalls.
//   - Multi-cycle mul/div occupancy of EX.
//   - Data-memory wait states.
//   - Exceptions raised in MEM.
// An exception raised while memory is stalled is held until the stall ends.
// Two saturating counters record stalled cycles and flushed cycles.
//
// Parameters
//   BRANCH_STAGE : 0 = branch resolved in ID, 1 = resolved in EX
//   MULDIV_LAT   : cycles a mul/div occupies EX (2..255)
//   CNT_W        : perf counter width
// Ports
//   clk, rst_n                        : clock, async active-low reset
//   jump, true_branch, loaduse_stall  : redirect / load-use requests
//   muldiv_start                      : mul/div instruction present in EX
//   mem_req, mem_ready                : MEM access valid / access completes
//   exception                         : MEM-stage exception pulse
//   cnt_clr                           : synchronous clear of both counters
//   ifid_flush, idex_flush, exmem_flush                 : bubble insert
//   pc_holdon, ifid_holdon, idex_holdon, exmem_holdon   : register freeze
//   muldiv_done                       : last EX cycle of a mul/div
//   stall_cnt, flush_cnt              : saturating perf counters
module hazard_ctrl_seq #(
  parameter int BRANCH_STAGE = 1,
  parameter int MULDIV_LAT   = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump,
  input  logic             true_branch,
  input  logic             loaduse_stall,
  input  logic             muldiv_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             exception,
  input  logic             cnt_clr,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_holdon,
  output logic             ifid_holdon,
  output logic             idex_holdon,
  output logic             exmem_holdon,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {IDLE, MULDIV, MEMWAIT} state_t;

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_LAT - 1);

  state_t           state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic             exc_pending_q, exc_pending_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_stall, exc_take, md_run, md_begin;

  assign mem_stall = mem_req & ~mem_ready;
  assign exc_take  = (exception | exc_pending_q) & ~mem_stall;
  // md_cnt is non-zero only while a mul/div is in flight. This also covers the
  // MEMWAIT release cycle, where the interrupted operation resumes at once so
  // that EX is never overwritten.
  assign md_run    = (state_q == MULDIV) | ((state_q == MEMWAIT) & (md_cnt_q != 8'd0));
  assign md_begin  = ~md_run & muldiv_start;

  // NOTE: every control register, including md_cnt, is asynchronously reset so
  // the pipeline is released the moment rst_n falls, even mid-operation.
  // NOTE: sequential state uses non-blocking assignments only, so that every
  // register samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      md_cnt_q      <= 8'd0;
      exc_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      exc_pending_q <= exc_pending_d;
    end
  end

  // NOTE: each combinational output gets a default before the priority chain.
  // Without the defaults, latches would be inferred.
  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    exc_pending_d = exc_pending_q;
    if (exc_take) begin
      // The exception aborts any mul/div in flight.
      state_d       = IDLE;
      md_cnt_d      = 8'd0;
      exc_pending_d = 1'b0;
    end else if (mem_stall) begin
      // md_cnt is frozen here. A non-zero value records the interrupted mul/div.
      state_d       = MEMWAIT;
      exc_pending_d = exc_pending_q | exception;
    end else if (md_begin) begin
      state_d  = MULDIV;
      md_cnt_d = MD_LOAD;
    end else if (md_run) begin
      md_cnt_d = md_cnt_q - 8'd1;
      state_d  = (md_cnt_q == 8'd1) ? IDLE : MULDIV;
    end else begin
      state_d = IDLE;
    end
  end

  always_comb begin
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    pc_holdon    = 1'b0;
    ifid_holdon  = 1'b0;
    idex_holdon  = 1'b0;
    exmem_holdon = 1'b0;
    muldiv_done  = 1'b0;
    // Outputs are gated by rst_n so that the pipeline is never frozen or
    // flushed while the controller is held in reset.
    if (rst_n) begin
      if (exc_take) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (mem_stall) begin
        pc_holdon    = 1'b1;
        ifid_holdon  = 1'b1;
        idex_holdon  = 1'b1;
        exmem_holdon = 1'b1;
      end else if (md_run | md_begin) begin
        pc_holdon   = 1'b1;
        ifid_holdon = 1'b1;
        idex_holdon = 1'b1;
        exmem_flush = 1'b1;
        muldiv_done = md_run & (md_cnt_q == 8'd1);
      end else if ((BRANCH_STAGE == 1) && true_branch) begin
        // An EX redirect squashes the stalled ID instruction, so it wins over
        // the load-use stall.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (loaduse_stall) begin
        pc_holdon   = 1'b1;
        ifid_holdon = 1'b1;
        idex_flush  = 1'b1;
      end else if (jump || ((BRANCH_STAGE == 0) && true_branch)) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_holdon && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((ifid_flush | idex_flush | exmem_flush) && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Testbench for hazard_ctrl_seq. It runs two instances with the same stimulus:
//   - dut0: BRANCH_STAGE=1, MULDIV_LAT=8, CNT_W=4
//   - dut1: BRANCH_STAGE=0, MULDIV_LAT=3, CNT_W=16
// Each instance is compared against a per-cycle behavioural model. The model
// tracks the remaining mul/div cycles, the pending exception and the counters
// as plain integers.
module tb_hazard_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jump, true_branch, loaduse_stall, muldiv_start;
  logic mem_req, mem_ready, exception, cnt_clr;

  // Output vector order: ifid_flush, idex_flush, exmem_flush, pc_holdon,
  // ifid_holdon, idex_holdon, exmem_holdon, muldiv_done.
  wire [7:0]  o0, o1;
  wire [3:0]  sc0, fc0;
  wire [15:0] sc1, fc1;

  always #5 clk = ~clk;

  hazard_ctrl_seq #(.BRANCH_STAGE(1), .MULDIV_LAT(8), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .jump(jump), .true_branch(true_branch),
    .loaduse_stall(loaduse_stall), .muldiv_start(muldiv_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .exception(exception),
    .cnt_clr(cnt_clr),
    .ifid_flush(o0[7]), .idex_flush(o0[6]), .exmem_flush(o0[5]),
    .pc_holdon(o0[4]), .ifid_holdon(o0[3]), .idex_holdon(o0[2]),
    .exmem_holdon(o0[1]), .muldiv_done(o0[0]),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_ctrl_seq #(.BRANCH_STAGE(0), .MULDIV_LAT(3), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .jump(jump), .true_branch(true_branch),
    .loaduse_stall(loaduse_stall), .muldiv_start(muldiv_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .exception(exception),
    .cnt_clr(cnt_clr),
    .ifid_flush(o1[7]), .idex_flush(o1[6]), .exmem_flush(o1[5]),
    .pc_holdon(o1[4]), .ifid_holdon(o1[3]), .idex_holdon(o1[2]),
    .exmem_holdon(o1[1]), .muldiv_done(o1[0]),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one entry per instance.
  int lat_a[2] = '{8, 3};
  int bs_a[2]  = '{1, 0};
  int max_a[2] = '{15, 65535};
  int md_left[2];
  bit pend[2];
  int m_sc[2];
  int m_fc[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      md_left[d] = 0;
      pend[d]    = 1'b0;
      m_sc[d]    = 0;
      m_fc[d]    = 0;
    end
  endtask

  // Produces this cycle's expected outputs and advances the model across the
  // next clock edge.
  task automatic model_cycle(input int d, output logic [7:0] e);
    bit stall;
    stall = mem_req && !mem_ready;
    e = 8'h00;
    if ((exception || pend[d]) && !stall) begin
      e = 8'b1110_0000;
      md_left[d] = 0;
      pend[d] = 1'b0;
    end else if (stall) begin
      e = 8'b0001_1110;
      if (exception) pend[d] = 1'b1;
    end else if (md_left[d] > 0 || muldiv_start) begin
      if (md_left[d] == 0) md_left[d] = lat_a[d];
      e = 8'b0011_1100;
      if (md_left[d] == 1) e[0] = 1'b1;
      md_left[d]--;
    end else if (bs_a[d] == 1 && true_branch) begin
      e = 8'b1100_0000;
    end else if (loaduse_stall) begin
      e = 8'b0101_1000;
    end else if (jump || (bs_a[d] == 0 && true_branch)) begin
      e = 8'b1000_0000;
    end
    if (cnt_clr) begin
      m_sc[d] = 0;
      m_fc[d] = 0;
    end else begin
      if (e[4] && m_sc[d] < max_a[d]) m_sc[d]++;
      if ((|e[7:5]) && m_fc[d] < max_a[d]) m_fc[d]++;
    end
  endtask

  task automatic set_in(input logic [7:0] v);
    {jump, true_branch, loaduse_stall, muldiv_start,
     mem_req, mem_ready, exception, cnt_clr} = v;
  endtask

  // One clock cycle. It is called just after a falling edge, with the inputs
  // already driven. The comb outputs are sampled before the rising edge and the
  // counters just after it.
  task automatic step();
    logic [7:0] e0, e1;
    #2;
    model_cycle(0, e0);
    model_cycle(1, e1);
    check("out0", 32'(o0), 32'(e0));
    check("out1", 32'(o1), 32'(e1));
    @(posedge clk);
    #1;
    check("stall_cnt0", 32'(sc0), 32'(m_sc[0]));
    check("flush_cnt0", 32'(fc0), 32'(m_fc[0]));
    check("stall_cnt1", 32'(sc1), 32'(m_sc[1]));
    check("flush_cnt1", 32'(fc1), 32'(m_fc[1]));
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    set_in(8'hFF);
    rst_n = 1'b0;
    #12;
    check("rst_out0", 32'(o0), 32'h0);
    check("rst_out1", 32'(o1), 32'h0);
    @(posedge clk);
    #1;
    check("rst_out0_edge", 32'(o0), 32'h0);
    check("rst_sc0", 32'(sc0), 32'h0);
    check("rst_fc0", 32'(fc0), 32'h0);
    check("rst_sc1", 32'(sc1), 32'h0);
    check("rst_fc1", 32'(fc1), 32'h0);

    @(negedge clk);
    set_in(8'h00);
    rst_n = 1'b1;
    jump = 1'b1;
    step();
    check("jump_flush_cnt0", 32'(fc0), 32'd1);
    jump = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;

    // A mul/div pulse holds the front of the pipeline for MULDIV_LAT cycles.
    muldiv_start = 1'b1;
    step();
    muldiv_start = 1'b0;
    repeat (10) step();
    check("md_stall_cnt0", 32'(sc0), 32'd8);

    // Memory wait of three cycles, with an exception in stall cycle 2.
    mem_req = 1'b1; mem_ready = 1'b0;
    step();
    exception = 1'b1;
    step();
    exception = 1'b0;
    step();
    mem_ready = 1'b1;
    step();
    mem_req = 1'b0; mem_ready = 1'b0;
    step();

    // EX redirect against load-use (dut0); ID redirect against load-use (dut1).
    true_branch = 1'b1; loaduse_stall = 1'b1;
    step();
    true_branch = 1'b0; loaduse_stall = 1'b0;
    step();

    // An exception in mul/div cycle 4 aborts the operation.
    muldiv_start = 1'b1;
    step();
    muldiv_start = 1'b0;
    step();
    step();
    exception = 1'b1;
    step();
    exception = 1'b0;
    repeat (6) step();

    // Saturation of the 4-bit counter, followed by a clear.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (20) step();
    check("sat_stall_cnt0", 32'(sc0), 32'd15);
    mem_req = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_stall_cnt0", 32'(sc0), 32'd0);

    // Reset asserted mid-mul/div drops all holds immediately.
    muldiv_start = 1'b1;
    step();
    muldiv_start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    check("rst_md_out0", 32'(o0), 32'h0);
    check("rst_md_out1", 32'(o1), 32'h0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step();

    // Reset asserted mid-memory-wait.
    mem_req = 1'b1; mem_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    check("rst_mw_out0", 32'(o0), 32'h0);
    check("rst_mw_sc0", 32'(sc0), 32'h0);
    @(negedge clk);
    model_reset();
    set_in(8'h00);
    rst_n = 1'b1;
    step();

    // Randomized traffic.
    repeat (600) begin
      jump          = ($urandom_range(0, 99) < 15);
      true_branch   = ($urandom_range(0, 99) < 15);
      loaduse_stall = ($urandom_range(0, 99) < 15);
      muldiv_start  = ($urandom_range(0, 99) < 10);
      mem_req       = ($urandom_range(0, 99) < 35);
      mem_ready     = ($urandom_range(0, 99) < 50);
      exception     = ($urandom_range(0, 99) < 5);
      cnt_clr       = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
